// File: rtl/three_mul_pkg.sv
// three_mul_pkg
//   Shared helpers for the serial divisibility detector.
//   rem_width() sizes the remainder register for a given modulus; it never
//   returns less than one bit.
package three_mul_pkg;

    function automatic int rem_width(input int divisor);
        return (divisor <= 2) ? 1 : $clog2(divisor);
    endfunction

endpackage

// File: rtl/three_mul.sv
// three_mul
//   Serial divisibility detector. Consumes one bit per clock, MSB first, and
//   flags whenever the value of every bit seen since reset is a multiple of
//   DIVISOR. Moore FSM whose state is the running remainder.
//
//   Ports
//     clk     rising-edge clock
//     reset   asynchronous active-low reset; clears the remainder at once
//     bit_in  next stream bit, sampled on every rising edge while reset=1
//     res     1 when the accumulated value mod DIVISOR == 0
//     rem     accumulated value mod DIVISOR (observability)
//
//   State (DIVISOR = 3)
//     state | meaning
//     S0    | value mod 3 == 0, rem = 0, res = 1
//     S1    | value mod 3 == 1, rem = 1
//     S2    | value mod 3 == 2, rem = 2
//   For other moduli state k means value mod DIVISOR == k.
module three_mul
    import three_mul_pkg::*;
#(
    parameter  int DIVISOR = 3,
    localparam int REM_W   = rem_width(DIVISOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    output logic             res,
    output logic [REM_W-1:0] rem
);

    localparam logic [REM_W:0] DIV_EXT = (REM_W + 1)'(DIVISOR);

    logic [REM_W-1:0] r_q;
    logic [REM_W-1:0] r_d;

    // Appending a bit doubles the value and adds the bit. With r < DIVISOR the
    // sum is below 2*DIVISOR, so one conditional subtraction fully reduces it.
    // The extra top bit keeps 2*(DIVISOR-1)+1 from overflowing.
    function automatic logic [REM_W:0] mod_step(input logic [REM_W-1:0] r,
                                                input logic             b);
        logic [REM_W:0] sum;
        sum = {r, b};
        return (sum >= DIV_EXT) ? (sum - DIV_EXT) : sum;
    endfunction

    always_comb begin
        r_d = REM_W'(mod_step(r_q, bit_in));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // Outputs decode only the register: no path from bit_in to res.
    assign rem = r_q;
    assign res = (r_q == '0);

endmodule

// File: tb/tb_three_mul.sv
module tb_three_mul;

    logic       clk;
    logic       reset;
    logic       bit3;
    logic       bit5;
    logic       res3;
    logic       res5;
    logic [1:0] rem3;
    logic [2:0] rem5;

    int checks   = 0;
    int failures = 0;

    int q3[$];
    int q5[$];

    three_mul #(.DIVISOR(3)) dut3 (
        .clk    (clk),
        .reset  (reset),
        .bit_in (bit3),
        .res    (res3),
        .rem    (rem3)
    );

    three_mul #(.DIVISOR(5)) dut5 (
        .clk    (clk),
        .reset  (reset),
        .bit_in (bit5),
        .res    (res5),
        .rem    (rem5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_int(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every cycle, just after the active edge, compare the DUT
    // outputs against the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (q3.size() != 0) begin
            int e;
            e = q3.pop_front();
            check_int("rem3", int'(rem3), e);
            check_int("res3", int'(res3), (e == 0) ? 1 : 0);
        end
        if (q5.size() != 0) begin
            int e;
            e = q5.pop_front();
            check_int("rem5", int'(rem5), e);
            check_int("res5", int'(res5), (e == 0) ? 1 : 0);
        end
    end

    task automatic send3(input logic b, input int exp_rem);
        @(negedge clk);
        bit3 = b;
        q3.push_back(exp_rem);
    endtask

    task automatic send5(input logic b, input int exp_rem);
        @(negedge clk);
        bit5 = b;
        q5.push_back(exp_rem);
    endtask

    task automatic idle_bits();
        @(negedge clk);
        bit3 = 1'b0;
        bit5 = 1'b0;
    endtask

    // Assert reset at a negedge (between active edges) and check the
    // outputs cleared without waiting for a clock edge.
    task automatic async_reset_check(input string tag);
        @(negedge clk);
        reset = 1'b0;
        bit3  = 1'b0;
        bit5  = 1'b0;
        #1;
        check_int({tag, "_rem3"}, int'(rem3), 0);
        check_int({tag, "_res3"}, int'(res3), 1);
        @(posedge clk);
        #1;
        check_int({tag, "_hold_rem3"}, int'(rem3), 0);
    endtask

    // Release at a negedge with the next bit already set up, so the first
    // rising edge with reset high samples that bit as the MSB.
    task automatic release_with3(input logic b, input int exp_rem);
        @(negedge clk);
        reset = 1'b1;
        bit3  = b;
        q3.push_back(exp_rem);
    endtask

    localparam int LONG_N = 15;
    logic [LONG_N-1:0] long_bits;
    int                long_rem [LONG_N] = '{1,0,0,0,1,0,0,1,0,0,0,1,0,1,2};

    initial begin
        long_bits = 15'b110011011001110;
        reset = 1'b0;
        bit3  = 1'b0;
        bit5  = 1'b0;

        // Held reset for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check_int("rst_rem3", int'(rem3), 0);
        check_int("rst_res3", int'(res3), 1);
        check_int("rst_rem5", int'(rem5), 0);

        // Stream 1,1 -> value 3.
        release_with3(1'b1, 1);
        send3(1'b1, 0);

        // Continue with a fresh stream after a reset taken between edges.
        async_reset_check("async1");
        release_with3(long_bits[LONG_N-1], long_rem[0]);
        for (int i = 1; i < LONG_N; i++) begin
            send3(long_bits[LONG_N-1-i], long_rem[i]);
        end

        // Reset in the middle of the clock high phase, not at an edge.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_int("async2_rem3", int'(rem3), 0);
        check_int("async2_res3", int'(res3), 1);

        // Leading zeros then 1,0,0,1 -> value 9.
        release_with3(1'b0, 0);
        send3(1'b0, 0);
        send3(1'b0, 0);
        send3(1'b1, 1);
        send3(1'b0, 2);
        send3(1'b0, 1);
        send3(1'b1, 0);

        // Mid-stream reset: 1,0 (rem 2), reset, then 1,1.
        async_reset_check("async3");
        release_with3(1'b1, 1);
        send3(1'b0, 2);
        async_reset_check("mid");
        release_with3(1'b1, 1);
        send3(1'b1, 0);
        idle_bits();

        // DIVISOR = 5: stream 1,0,1,0 -> value 10.
        async_reset_check("async5");
        @(negedge clk);
        reset = 1'b1;
        bit5  = 1'b1;
        q5.push_back(1);
        send5(1'b0, 2);
        send5(1'b1, 0);
        send5(1'b0, 0);
        idle_bits();

        repeat (3) @(posedge clk);
        #2;
        check_int("q3_drained", q3.size(), 0);
        check_int("q5_drained", q5.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
